ring_cal_sequencer: RTL and testbench

//  Autonomous calibration sequencer for the ring oscillator. Sweeps trim codes over a range.
//  At each code it gates the ring for a fixed number of wb_clk_i cycles, samples the ring counter
//  and streams (trim, count) results. It also tracks the code whose count is closest to a target.

---
 rtl/ring_cal_pkg.sv | 41 ++++
 rtl/ring_cal_if.sv | 52 +++++
 rtl/ring_cal_timer.sv | 33 +++
 rtl/ring_cal_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_ring_cal_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_cal_pkg
// Description : State encodings and distance helper for the ring calibration
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_cal_pkg;

  localparam int DIST_BITS = 33;
  localparam int ARG_BITS  = DIST_BITS - 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_GATE   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SAMPLE = 3'd4;
  localparam logic [2:0] ST_EMIT   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_APPLY  = ST_APPLY,
    S_GATE   = ST_GATE,
    S_HOLD   = ST_HOLD,
    S_SAMPLE = ST_SAMPLE,
    S_EMIT   = ST_EMIT,
    S_DONE   = ST_DONE
  } state_t;

  // Unsigned |a-b|; one spare bit so the result never wraps.
  function automatic logic [DIST_BITS-1:0] abs_dist(input logic [ARG_BITS-1:0] a,
                                                    input logic [ARG_BITS-1:0] b);
    logic [DIST_BITS-1:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, b} - {1'b0, a};
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_cal_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_cal_if
// Description : Configuration, ring control, result stream and status bundle
//               between the calibration sequencer and its host.
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_cal_if #(
  parameter int TRIM_BITS  = 28,
  parameter int COUNT_BITS = 17,
  parameter int TIMER_BITS = 16
);
  logic                  cfg_start;
  logic                  cfg_abort;
  logic [TRIM_BITS-1:0]  cfg_trim_lo;
  logic [TRIM_BITS-1:0]  cfg_trim_hi;
  logic [TRIM_BITS-1:0]  cfg_trim_step;
  logic [TIMER_BITS-1:0] cfg_settle;
  logic [TIMER_BITS-1:0] cfg_gate;
  logic [COUNT_BITS-1:0] cfg_target;
  logic [COUNT_BITS-1:0] count_value;

  logic                  ring_start;
  logic [TRIM_BITS-1:0]  ring_trim;
  logic                  counter_clear;

  logic                  res_valid;
  logic                  res_ready;
  logic [TRIM_BITS-1:0]  res_trim;
  logic [COUNT_BITS-1:0] res_count;

  logic                  busy;
  logic                  done;
  logic                  err;
  logic [TRIM_BITS-1:0]  best_trim;
  logic [COUNT_BITS-1:0] best_count;

  modport master (
    input  cfg_start, cfg_abort, cfg_trim_lo, cfg_trim_hi, cfg_trim_step,
           cfg_settle, cfg_gate, cfg_target, count_value, res_ready,
    output ring_start, ring_trim, counter_clear, res_valid, res_trim, res_count,
           busy, done, err, best_trim, best_count
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_trim_lo, cfg_trim_hi, cfg_trim_step,
           cfg_settle, cfg_gate, cfg_target, count_value, res_ready,
    input  ring_start, ring_trim, counter_clear, res_valid, res_trim, res_count,
           busy, done, err, best_trim, best_count
  );
endinterface
`default_nettype wire

// File: rtl/ring_cal_timer.sv
`default_nettype none
// ============================================================================
// Module      : ring_cal_timer
// Description : Loadable down-counter with zero flag; a load of N-1 yields a
//               phase lasting N cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_cal_timer #(
  parameter int TIMER_BITS = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  load,
  input  wire logic [TIMER_BITS-1:0] load_value,
  output logic                       zero
);

  logic [TIMER_BITS-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TIMER_BITS'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ring_cal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ring_cal_sequencer
// Description : Sweeps ring-oscillator trim codes, gates the ring per code,
//               streams (trim, count) results and tracks the code closest to
//               a target count.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_cal_sequencer
  import ring_cal_pkg::*;
#(
  parameter int TRIM_BITS   = 28,
  parameter int COUNT_BITS  = 17,
  parameter int TIMER_BITS  = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic  wb_clk_i,
  input  wire logic  wb_rst_i,
  ring_cal_if.master bus
);

  localparam logic [TIMER_BITS-1:0] c_hold_load = TIMER_BITS'(HOLD_CYCLES - 1);

  state_t                r_state;
  logic [TRIM_BITS-1:0]  r_hi;
  logic [TRIM_BITS-1:0]  r_step;
  logic [TIMER_BITS-1:0] r_settle_load;
  logic [TIMER_BITS-1:0] r_gate_load;
  logic [COUNT_BITS-1:0] r_target;

  logic                  r_ring_start;
  logic [TRIM_BITS-1:0]  r_ring_trim;
  logic                  r_counter_clear;
  logic                  r_res_valid;
  logic [TRIM_BITS-1:0]  r_res_trim;
  logic [COUNT_BITS-1:0] r_res_count;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [TRIM_BITS-1:0]  r_best_trim;
  logic [COUNT_BITS-1:0] r_best_count;
  logic [COUNT_BITS:0]   r_best_dist;
  logic                  r_best_valid;

  logic                  w_cfg_bad;
  logic [TIMER_BITS-1:0] w_cfg_settle_load;
  logic [TIMER_BITS-1:0] w_cfg_gate_load;
  logic [TRIM_BITS-1:0]  w_cfg_step;
  logic [TRIM_BITS:0]    w_next_sum;
  logic                  w_last;
  logic [DIST_BITS-1:0]  w_dist;
  logic                  w_better;
  logic                  w_tmr_load;
  logic [TIMER_BITS-1:0] w_tmr_value;
  logic                  w_tmr_zero;

  assign w_cfg_bad         = (bus.cfg_trim_lo > bus.cfg_trim_hi);
  assign w_cfg_settle_load = (bus.cfg_settle == '0) ? '0 : bus.cfg_settle - TIMER_BITS'(1);
  assign w_cfg_gate_load   = (bus.cfg_gate == '0) ? '0 : bus.cfg_gate - TIMER_BITS'(1);
  assign w_cfg_step        = (bus.cfg_trim_step == '0) ? TRIM_BITS'(1) : bus.cfg_trim_step;

  // Carry out of the code add ends the sweep so it never wraps past all-ones.
  assign w_next_sum = {1'b0, r_ring_trim} + {1'b0, r_step};
  assign w_last     = w_next_sum[TRIM_BITS] || (w_next_sum[TRIM_BITS-1:0] > r_hi);

  assign w_dist   = abs_dist(ARG_BITS'(bus.count_value), ARG_BITS'(r_target));
  assign w_better = !r_best_valid || (w_dist < DIST_BITS'(r_best_dist));

  // Timer reload coincides with each state entry, so it is decoded here.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    if (!bus.cfg_abort) begin
      case (r_state)
        S_IDLE: if (bus.cfg_start && !w_cfg_bad) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = w_cfg_settle_load;
        end
        S_APPLY: if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = r_gate_load;
        end
        S_GATE: if (w_tmr_zero) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = c_hold_load;
        end
        S_EMIT: if (bus.res_ready && !w_last) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = r_settle_load;
        end
        default: ;
      endcase
    end
  end

  ring_cal_timer #(
    .TIMER_BITS (TIMER_BITS)
  ) u_timer (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load       (w_tmr_load),
    .load_value (w_tmr_value),
    .zero       (w_tmr_zero)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state         <= S_IDLE;
      r_hi            <= '0;
      r_step          <= '0;
      r_settle_load   <= '0;
      r_gate_load     <= '0;
      r_target        <= '0;
      r_ring_start    <= 1'b0;
      r_ring_trim     <= '0;
      r_counter_clear <= 1'b1;
      r_res_valid     <= 1'b0;
      r_res_trim      <= '0;
      r_res_count     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_best_trim     <= '0;
      r_best_count    <= '0;
      r_best_dist     <= '0;
      r_best_valid    <= 1'b0;
    end else if (bus.cfg_abort) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_ring_start    <= 1'b0;
      r_counter_clear <= 1'b1;
      r_res_valid     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_best_trim  <= '0;
            r_best_count <= '0;
            r_best_dist  <= '0;
            r_best_valid <= 1'b0;
            if (w_cfg_bad) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_hi            <= bus.cfg_trim_hi;
              r_step          <= w_cfg_step;
              r_settle_load   <= w_cfg_settle_load;
              r_gate_load     <= w_cfg_gate_load;
              r_target        <= bus.cfg_target;
              r_ring_trim     <= bus.cfg_trim_lo;
              r_ring_start    <= 1'b0;
              r_counter_clear <= 1'b1;
              r_busy          <= 1'b1;
              r_state         <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          if (w_tmr_zero) begin
            r_ring_start    <= 1'b1;
            r_counter_clear <= 1'b0;
            r_state         <= S_GATE;
          end
        end
        S_GATE: begin
          if (w_tmr_zero) begin
            r_ring_start <= 1'b0;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_tmr_zero) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_res_count <= bus.count_value;
          r_res_trim  <= r_ring_trim;
          r_res_valid <= 1'b1;
          if (w_better) begin
            r_best_valid <= 1'b1;
            r_best_trim  <= r_ring_trim;
            r_best_count <= bus.count_value;
            r_best_dist  <= w_dist[COUNT_BITS:0];
          end
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.res_ready) begin
            r_res_valid     <= 1'b0;
            r_counter_clear <= 1'b1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ring_trim <= w_next_sum[TRIM_BITS-1:0];
              r_state     <= S_APPLY;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ring_start    = r_ring_start;
  assign bus.ring_trim     = r_ring_trim;
  assign bus.counter_clear = r_counter_clear;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_trim      = r_res_trim;
  assign bus.res_count     = r_res_count;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.best_trim     = r_best_trim;
  assign bus.best_count    = r_best_count;

endmodule
`default_nettype wire

// File: tb/tb_ring_cal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_cal_sequencer
// Description : Directed self-checking bench for ring_cal_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ring_cal_sequencer;

  localparam int TB_TRIM  = 28;
  localparam int TB_COUNT = 17;
  localparam int TB_TIMER = 16;
  localparam logic [TB_TRIM-1:0] ALL1 = {TB_TRIM{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  ring_cal_if #(.TRIM_BITS(TB_TRIM), .COUNT_BITS(TB_COUNT), .TIMER_BITS(TB_TIMER)) bus ();

  ring_cal_sequencer #(
    .TRIM_BITS   (TB_TRIM),
    .COUNT_BITS  (TB_COUNT),
    .TIMER_BITS  (TB_TIMER),
    .HOLD_CYCLES (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Ring model: count = |trim-5|*10 + 100, truncated to the counter width.
  function automatic logic [TB_COUNT-1:0] model(input logic [TB_TRIM-1:0] t);
    longint d;
    longint v;
    d = (t >= 5) ? longint'(t) - 5 : 5 - longint'(t);
    v = d * 10 + 100;
    return v[TB_COUNT-1:0];
  endfunction

  always_comb bus.count_value = model(bus.ring_trim);

  int n_res, n_gates, cur_gate, first_gate_cyc, cyc;
  bit saw_busy, saw_ring, timed_out;
  logic [TB_TRIM-1:0]  got_trim [8];
  logic [TB_COUNT-1:0] got_count[8];
  int                  gate_len [8];

  task automatic do_start(input logic [TB_TRIM-1:0] lo, input logic [TB_TRIM-1:0] hi,
                          input logic [TB_TRIM-1:0] step, input logic [TB_TIMER-1:0] settle,
                          input logic [TB_TIMER-1:0] gate, input logic [TB_COUNT-1:0] target);
    repeat (2) @(negedge clk);
    bus.cfg_trim_lo   = lo;
    bus.cfg_trim_hi   = hi;
    bus.cfg_trim_step = step;
    bus.cfg_settle    = settle;
    bus.cfg_gate      = gate;
    bus.cfg_target    = target;
    bus.cfg_start     = 1'b1;
  endtask

  // Runs until done with busy low, logging results and gate run lengths.
  task automatic collect(input int budget);
    n_res = 0; n_gates = 0; cur_gate = 0; first_gate_cyc = 0; cyc = 0;
    saw_busy = 0; saw_ring = 0; timed_out = 0;
    for (int i = 0; i < 8; i++) begin
      got_trim[i] = 'x; got_count[i] = 'x; gate_len[i] = -1;
    end
    forever begin
      @(negedge clk);
      cyc++;
      bus.cfg_start = 1'b0;
      if (bus.ring_start) begin
        saw_ring = 1;
        cur_gate++;
        if (first_gate_cyc == 0) first_gate_cyc = cyc;
      end else if (cur_gate != 0) begin
        if (n_gates < 8) gate_len[n_gates] = cur_gate;
        n_gates++;
        cur_gate = 0;
      end
      if (bus.busy) saw_busy = 1;
      if (bus.res_valid && bus.res_ready) begin
        if (n_res < 8) begin
          got_trim[n_res]  = bus.res_trim;
          got_count[n_res] = bus.res_count;
        end
        n_res++;
      end
      if (bus.done && !bus.busy) break;
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.cfg_start = 0; bus.cfg_abort = 0; bus.res_ready = 1;
    bus.cfg_trim_lo = '0; bus.cfg_trim_hi = '0; bus.cfg_trim_step = '0;
    bus.cfg_settle = '0; bus.cfg_gate = '0; bus.cfg_target = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.counter_clear !== 1'b1) begin failures++; $display("FAIL reset_clear: got %b want 1", bus.counter_clear); end
    checks++;
    if ({bus.ring_start, bus.res_valid, bus.busy, bus.done, bus.err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {bus.ring_start, bus.res_valid, bus.busy, bus.done, bus.err});
    end
    checks++;
    if ({bus.ring_trim, bus.res_trim, bus.best_trim, bus.res_count, bus.best_count} !== '0) begin
      failures++; $display("FAIL reset_data: trim=%0h best_trim=%0h best_count=%0d want 0", bus.ring_trim, bus.best_trim, bus.best_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_sweep();
    do_start(28'd3, 28'd7, 28'd2, 16'd2, 16'd10, 17'd100);
    collect(600);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout: cycles=%0d want done", cyc); end
    checks++;
    if (n_res !== 3) begin failures++; $display("FAIL basic_nres: got %0d want 3", n_res); end
    for (int i = 0; i < 3; i++) begin
      logic [TB_TRIM-1:0] et;
      et = TB_TRIM'(3 + 2 * i);
      checks++;
      if (got_trim[i] !== et || got_count[i] !== model(et)) begin
        failures++; $display("FAIL basic_res%0d: got trim=%0d count=%0d want trim=%0d count=%0d", i, got_trim[i], got_count[i], et, model(et));
      end
      checks++;
      if (gate_len[i] !== 10) begin failures++; $display("FAIL basic_gate%0d: got %0d want 10", i, gate_len[i]); end
    end
    checks++;
    if (first_gate_cyc !== 3) begin failures++; $display("FAIL basic_latency: got %0d want 3", first_gate_cyc); end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL basic_status: done=%b err=%b want 1 0", bus.done, bus.err); end
    checks++;
    if (bus.best_trim !== 28'd5 || bus.best_count !== 17'd100) begin
      failures++; $display("FAIL basic_best: got %0d/%0d want 5/100", bus.best_trim, bus.best_count);
    end
  endtask

  task automatic test_tie();
    do_start(28'd4, 28'd6, 28'd2, 16'd1, 16'd3, 17'd100);
    collect(300);
    checks++;
    if (n_res !== 2 || timed_out) begin failures++; $display("FAIL tie_nres: got %0d want 2", n_res); end
    checks++;
    if (bus.best_trim !== 28'd4 || bus.best_count !== 17'd110) begin
      failures++; $display("FAIL tie_best: got %0d/%0d want 4/110", bus.best_trim, bus.best_count);
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  held;
    bus.res_ready = 1'b0;
    do_start(28'd2, 28'd2, 28'd1, 16'd1, 16'd3, 17'd100);
    @(negedge clk);
    bus.cfg_start = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", bus.res_valid); end
    held = 1;
    repeat (20) begin
      @(negedge clk);
      if (!(bus.res_valid === 1'b1 && bus.res_trim === 28'd2 && bus.res_count === 17'd130 &&
            bus.counter_clear === 1'b0 && bus.busy === 1'b1 && bus.ring_start === 1'b0)) held = 0;
    end
    checks++;
    if (!held) begin
      failures++; $display("FAIL bp_hold: valid=%b trim=%0d count=%0d clear=%b want 1 2 130 0 held", bus.res_valid, bus.res_trim, bus.res_count, bus.counter_clear);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.busy, bus.done, bus.counter_clear} !== 4'b0011) begin
      failures++; $display("FAIL bp_single_done: valid/busy/done/clear=%b want 0011", {bus.res_valid, bus.busy, bus.done, bus.counter_clear});
    end
  endtask

  task automatic test_error();
    do_start(28'd9, 28'd4, 28'd1, 16'd1, 16'd1, 17'd100);
    collect(20);
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b1 || timed_out) begin
      failures++; $display("FAIL err_flags: err=%b done=%b want 1 1", bus.err, bus.done);
    end
    checks++;
    if (saw_busy || saw_ring || n_res != 0) begin
      failures++; $display("FAIL err_quiet: busy=%0d ring=%0d nres=%0d want 0 0 0", saw_busy, saw_ring, n_res);
    end
  endtask

  task automatic test_abort();
    int n;
    do_start(28'd0, 28'd10, 28'd1, 16'd1, 16'd10, 17'd100);
    @(negedge clk);
    bus.cfg_start = 1'b0;
    n = 0;
    while (!bus.ring_start && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    bus.cfg_abort = 1'b1;
    @(negedge clk);
    bus.cfg_abort = 1'b0;
    checks++;
    if ({bus.ring_start, bus.counter_clear, bus.busy, bus.done, bus.res_valid, bus.err} !== 6'b010000) begin
      failures++; $display("FAIL abort_state: start/clear/busy/done/valid/err=%b want 010000",
                           {bus.ring_start, bus.counter_clear, bus.busy, bus.done, bus.res_valid, bus.err});
    end
    do_start(28'd1, 28'd1, 28'd1, 16'd0, 16'd0, 17'd100);
    collect(200);
    checks++;
    if (n_res !== 1 || got_trim[0] !== 28'd1 || gate_len[0] !== 1 || bus.done !== 1'b1) begin
      failures++; $display("FAIL abort_restart: nres=%0d trim=%0d gate=%0d done=%b want 1 1 1 1", n_res, got_trim[0], gate_len[0], bus.done);
    end
    repeat (2) @(negedge clk);
    bus.cfg_start = 1'b1;
    bus.cfg_abort = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL abort_wins: busy=%b done=%b want 0 1", bus.busy, bus.done);
    end
  endtask

  task automatic test_wrap();
    logic [TB_TRIM-1:0] t0, t1;
    t0 = ALL1 - 28'd4;
    t1 = ALL1 - 28'd1;
    do_start(t0, ALL1, 28'd3, 16'd0, 16'd0, 17'd100);
    collect(300);
    checks++;
    if (n_res !== 2 || timed_out) begin failures++; $display("FAIL wrap_nres: got %0d want 2", n_res); end
    checks++;
    if (got_trim[0] !== t0 || got_trim[1] !== t1 || got_count[1] !== model(t1)) begin
      failures++; $display("FAIL wrap_trims: got %0h %0h want %0h %0h", got_trim[0], got_trim[1], t0, t1);
    end
    checks++;
    if (gate_len[0] !== 1 || gate_len[1] !== 1) begin
      failures++; $display("FAIL wrap_gate1: got %0d %0d want 1 1", gate_len[0], gate_len[1]);
    end
  endtask

  task automatic test_step_zero();
    do_start(28'd0, 28'd2, 28'd0, 16'd1, 16'd0, 17'd100);
    collect(300);
    checks++;
    if (n_res !== 3 || got_trim[0] !== 28'd0 || got_trim[1] !== 28'd1 || got_trim[2] !== 28'd2) begin
      failures++; $display("FAIL step0_trims: n=%0d got %0d %0d %0d want 0 1 2", n_res, got_trim[0], got_trim[1], got_trim[2]);
    end
    checks++;
    if (bus.best_trim !== 28'd2 || bus.best_count !== 17'd130) begin
      failures++; $display("FAIL step0_best: got %0d/%0d want 2/130", bus.best_trim, bus.best_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit stray;
    do_start(28'd0, 28'd5, 28'd1, 16'd1, 16'd8, 17'd100);
    @(negedge clk);
    bus.cfg_start = 1'b0;
    n = 0;
    while (!bus.ring_start && n < 50) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ring_start, bus.busy, bus.res_valid, bus.counter_clear} !== 4'b0001 || bus.ring_trim !== '0) begin
      failures++; $display("FAIL rst_mid: start/busy/valid/clear=%b trim=%0d want 0001 0",
                           {bus.ring_start, bus.busy, bus.res_valid, bus.counter_clear}, bus.ring_trim);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) stray = 1;
    end
    checks++;
    if (stray) begin failures++; $display("FAIL rst_no_result: activity=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_tie();
    test_backpressure();
    test_error();
    test_abort();
    test_wrap();
    test_step_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
